shift_register_universal: RTL and testbench

- Parametrised successor to the single-direction accumulator shift register used by the sequential multiplier datapath.
- Adds direction select, logical/arithmetic/rotate modes, and a self-timed burst mode: a start pulse triggers N consecutive shifts, with busy/done status.
- Used by the MxV and multiplier datapaths so the controller FSM no longer counts shift cycles itself.

---
 rtl/shift_register_universal.sv | 141 ++++++++++++++
 tb/tb_shift_register_universal.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single-step shift and a
// self-timed burst of shiftCount shifts with busy/done status.
//
// Handshake: there is no valid/ready pair. Strobes (load, start, shift) are
// sampled only in IDLE with priority load > start > shift. While busy is high
// every strobe is ignored, and only sys_reset/reset take effect. done is a
// one-cycle pulse that marks burst completion and needs no acknowledge.
module shift_register_universal #(
    parameter int WORD_LENGTH = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sys_reset,
    input  logic                   load,
    input  logic [WORD_LENGTH-1:0] parallelInput,
    input  logic                   shift,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] shiftCount,
    input  logic                   dir,
    input  logic [1:0]             mode,
    input  logic                   serialInput,
    output logic                   serialOutput,
    output logic [WORD_LENGTH-1:0] parallelOutput,
    output logic                   busy,
    output logic                   done,
    output logic                   state_dbg
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    state_t                 state;
    logic [WORD_LENGTH-1:0] data_q;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   dir_l;
    logic [1:0]             mode_l;

    // Step result packed as {bit shifted out, new register value}.
    logic [WORD_LENGTH:0]   live_step;
    logic [WORD_LENGTH:0]   burst_step;

    function automatic logic [WORD_LENGTH:0] step_fn(
        input logic [WORD_LENGTH-1:0] r,
        input logic                   d,
        input logic [1:0]             m,
        input logic                   sin
    );
        logic fill;
        logic [WORD_LENGTH:0] res;
        if (!d) begin
            // Left: MSB leaves, fill enters at bit 0.
            if (m == MODE_ARITH)       fill = 1'b0;
            else if (m == MODE_ROTATE) fill = r[WORD_LENGTH-1];
            else                       fill = sin;
            res = {r[WORD_LENGTH-1], r[WORD_LENGTH-2:0], fill};
        end else begin
            // Right: LSB leaves, fill enters at the MSB (sign bit in arithmetic).
            if (m == MODE_ARITH)       fill = r[WORD_LENGTH-1];
            else if (m == MODE_ROTATE) fill = r[0];
            else                       fill = sin;
            res = {r[0], fill, r[WORD_LENGTH-1:1]};
        end
        return res;
    endfunction

    // Single steps use the live controls; bursts use the controls latched at start.
    always_comb begin
        live_step  = step_fn(data_q, dir, mode, serialInput);
        burst_step = step_fn(data_q, dir_l, mode_l, serialInput);
    end

    // Control FSM and datapath registers; sys_reset outranks every strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            data_q       <= '0;
            serialOutput <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            remaining    <= '0;
            dir_l        <= 1'b0;
            mode_l       <= 2'b00;
        end else if (sys_reset) begin
            state        <= ST_IDLE;
            data_q       <= '0;
            serialOutput <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            remaining    <= '0;
            dir_l        <= 1'b0;
            mode_l       <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        data_q <= parallelInput;
                    end else if (start) begin
                        if (shiftCount != '0) begin
                            remaining <= shiftCount;
                            dir_l     <= dir;
                            mode_l    <= mode;
                            state     <= ST_SHIFT;
                            busy      <= 1'b1;
                        end else begin
                            // Zero-length burst completes immediately.
                            done <= 1'b1;
                        end
                    end else if (shift) begin
                        serialOutput <= live_step[WORD_LENGTH];
                        data_q       <= live_step[WORD_LENGTH-1:0];
                    end
                end
                ST_SHIFT: begin
                    serialOutput <= burst_step[WORD_LENGTH];
                    data_q       <= burst_step[WORD_LENGTH-1:0];
                    remaining    <= remaining - 1'b1;
                    if (remaining == {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign parallelOutput = data_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal: expected output tuples are
// queued as each cycle's stimulus is driven and checked after the edge.
module tb_shift_register_universal;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sys_reset;
    logic          load;
    logic [W-1:0]  parallelInput;
    logic          shift;
    logic          start;
    logic [CW-1:0] shiftCount;
    logic          dir;
    logic [1:0]    mode;
    logic          serialInput;
    logic          serialOutput;
    logic [W-1:0]  parallelOutput;
    logic          busy;
    logic          done;
    logic          state_dbg;

    int total = 0;
    int bad   = 0;

    // Packed expectation: {busy, done, serialOutput, parallelOutput}.
    logic [W+2:0] exp_q[$];

    shift_register_universal #(.WORD_LENGTH(W), .COUNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .sys_reset     (sys_reset),
        .load          (load),
        .parallelInput (parallelInput),
        .shift         (shift),
        .start         (start),
        .shiftCount    (shiftCount),
        .dir           (dir),
        .mode          (mode),
        .serialInput   (serialInput),
        .serialOutput  (serialOutput),
        .parallelOutput(parallelOutput),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] d, input logic so,
                            input logic b, input logic dn);
        exp_q.push_back({b, dn, so, d});
    endtask

    // Pop one expectation and compare all observable outputs against it.
    task automatic check_out(input string tag);
        logic [W+2:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        total++;
        assert (parallelOutput === e[W-1:0]) else begin
            bad++;
            $error("FAIL %s.data: got %h want %h", tag, parallelOutput, e[W-1:0]);
        end
        total++;
        assert (serialOutput === e[W]) else begin
            bad++;
            $error("FAIL %s.sout: got %b want %b", tag, serialOutput, e[W]);
        end
        total++;
        assert (done === e[W+1]) else begin
            bad++;
            $error("FAIL %s.done: got %b want %b", tag, done, e[W+1]);
        end
        total++;
        assert (busy === e[W+2]) else begin
            bad++;
            $error("FAIL %s.busy: got %b want %b", tag, busy, e[W+2]);
        end
    endtask

    // One clock with the currently driven inputs, then check the result.
    task automatic cyc(input logic [W-1:0] d, input logic so, input logic b,
                       input logic dn, input string tag);
        push_exp(d, so, b, dn);
        tick();
        check_out(tag);
    endtask

    task automatic idle_inputs();
        load  = 1'b0;
        shift = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        reset = 1'b0; sys_reset = 1'b0; load = 1'b0; parallelInput = '0;
        shift = 1'b0; start = 1'b0; shiftCount = '0; dir = 1'b0; mode = 2'b00;
        serialInput = 1'b0;

        // Reset state
        tick(); tick();
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("reset");
        total++;
        assert (state_dbg === 1'b0) else begin
            bad++;
            $error("FAIL reset.state: got %b want 0", state_dbg);
        end
        reset = 1'b1;
        tick();

        // Burst left logical, serialInput=1
        load = 1'b1; parallelInput = 8'hB4;
        cyc(8'hB4, 1'b0, 1'b0, 1'b0, "t1.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd3; dir = 1'b0; mode = 2'b00;
        serialInput = 1'b1;
        cyc(8'hB4, 1'b0, 1'b1, 1'b0, "t1.start");
        start = 1'b0;
        cyc(8'h69, 1'b1, 1'b1, 1'b0, "t1.s1");
        cyc(8'hD3, 1'b0, 1'b1, 1'b0, "t1.s2");
        cyc(8'hA7, 1'b1, 1'b0, 1'b1, "t1.s3");
        cyc(8'hA7, 1'b1, 1'b0, 1'b0, "t1.after");

        // Burst right arithmetic, negative then positive operand
        load = 1'b1; parallelInput = 8'h90;
        cyc(8'h90, 1'b1, 1'b0, 1'b0, "t2.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd2; dir = 1'b1; mode = 2'b01;
        cyc(8'h90, 1'b1, 1'b1, 1'b0, "t2.start");
        start = 1'b0;
        cyc(8'hC8, 1'b0, 1'b1, 1'b0, "t2.s1");
        cyc(8'hE4, 1'b0, 1'b0, 1'b1, "t2.s2");
        load = 1'b1; parallelInput = 8'h10;
        cyc(8'h10, 1'b0, 1'b0, 1'b0, "t2b.load");
        load = 1'b0; start = 1'b1;
        cyc(8'h10, 1'b0, 1'b1, 1'b0, "t2b.start");
        start = 1'b0;
        cyc(8'h08, 1'b0, 1'b1, 1'b0, "t2b.s1");
        cyc(8'h04, 1'b0, 1'b0, 1'b1, "t2b.s2");

        // Single-step rotate right then left
        load = 1'b1; parallelInput = 8'h81;
        cyc(8'h81, 1'b0, 1'b0, 1'b0, "t3.load");
        load = 1'b0; shift = 1'b1; dir = 1'b1; mode = 2'b10;
        cyc(8'hC0, 1'b1, 1'b0, 1'b0, "t3.rr");
        dir = 1'b0;
        cyc(8'h81, 1'b1, 1'b0, 1'b0, "t3.rl");
        shift = 1'b0;
        cyc(8'h81, 1'b1, 1'b0, 1'b0, "t3.hold");

        // Burst longer than the word, with ignored strobes mid-burst
        load = 1'b1; parallelInput = 8'hFF;
        cyc(8'hFF, 1'b1, 1'b0, 1'b0, "t4.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd10; dir = 1'b0; mode = 2'b00;
        serialInput = 1'b0;
        cyc(8'hFF, 1'b1, 1'b1, 1'b0, "t4.start");
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k >= 3 && k <= 6) begin
                load = 1'b1; parallelInput = 8'h55; shift = 1'b1;
                dir = (k % 2 == 1); mode = 2'b10; start = 1'b1; shiftCount = 4'd1;
            end else begin
                idle_inputs();
                dir = 1'b0; mode = 2'b00;
            end
            v = 8'hFF;
            v = v << k;
            cyc(v, (k <= 8), (k < 10), (k == 10), $sformatf("t4.s%0d", k));
        end
        idle_inputs();
        cyc(8'h00, 1'b0, 1'b0, 1'b0, "t4.after");

        // Zero-length burst, then a start accepted while done is high
        load = 1'b1; parallelInput = 8'h3C;
        cyc(8'h3C, 1'b0, 1'b0, 1'b0, "t5.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd0;
        cyc(8'h3C, 1'b0, 1'b0, 1'b1, "t5.zero");
        start = 1'b0;
        cyc(8'h3C, 1'b0, 1'b0, 1'b0, "t5.after");
        start = 1'b1;
        cyc(8'h3C, 1'b0, 1'b0, 1'b1, "t5.zero2");
        shiftCount = 4'd1; dir = 1'b0; mode = 2'b10;
        cyc(8'h3C, 1'b0, 1'b1, 1'b0, "t5.b2b");
        start = 1'b0;
        cyc(8'h78, 1'b0, 1'b0, 1'b1, "t5.s1");

        // Synchronous clear mid-burst
        load = 1'b1; parallelInput = 8'hA5;
        cyc(8'hA5, 1'b0, 1'b0, 1'b0, "t6.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd5; dir = 1'b1; mode = 2'b00;
        serialInput = 1'b1;
        cyc(8'hA5, 1'b0, 1'b1, 1'b0, "t6.start");
        start = 1'b0;
        cyc(8'hD2, 1'b1, 1'b1, 1'b0, "t6.s1");
        cyc(8'hE9, 1'b0, 1'b1, 1'b0, "t6.s2");
        sys_reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0, 1'b0, "t6.sysrst");
        sys_reset = 1'b0;
        cyc(8'h00, 1'b0, 1'b0, 1'b0, "t6.idle");

        // Asynchronous reset mid-burst, checked between edges
        load = 1'b1; parallelInput = 8'hA5;
        cyc(8'hA5, 1'b0, 1'b0, 1'b0, "t7.load");
        load = 1'b0; start = 1'b1;
        cyc(8'hA5, 1'b0, 1'b1, 1'b0, "t7.start");
        start = 1'b0;
        cyc(8'hD2, 1'b1, 1'b1, 1'b0, "t7.s1");
        cyc(8'hE9, 1'b0, 1'b1, 1'b0, "t7.s2");
        #1;
        reset = 1'b0;
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        check_out("t7.async");
        #1;
        reset = 1'b1;

        // New burst runs normally after the reset
        load = 1'b1; parallelInput = 8'hB4;
        cyc(8'hB4, 1'b0, 1'b0, 1'b0, "t8.load");
        load = 1'b0; start = 1'b1; shiftCount = 4'd3; dir = 1'b0; mode = 2'b00;
        serialInput = 1'b1;
        cyc(8'hB4, 1'b0, 1'b1, 1'b0, "t8.start");
        start = 1'b0;
        cyc(8'h69, 1'b1, 1'b1, 1'b0, "t8.s1");
        cyc(8'hD3, 1'b0, 1'b1, 1'b0, "t8.s2");
        cyc(8'hA7, 1'b1, 1'b0, 1'b1, "t8.s3");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard.leftover: got %0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
